// File: rtl/imm_encoder.sv
// Two-stage instruction encoder: stage 1 packs fields and range-checks the
// immediate; stage 2 holds the encoded word for a valid/ready consumer.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic             out_err,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] enc_count
);

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  logic [31:0]      pack_ir;
  logic             pack_err;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_ir_q, s1_ir_d;
  logic             s1_err_q, s1_err_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_ir_q, out_ir_d;
  logic             out_err_q, out_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  logic s2_load;
  logic s2_take;
  logic accept;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    pack_ir       = '0;
    pack_err      = 1'b0;
    pack_ir[6:0]  = in_opcode;
    case (fmt_e'(in_fmt))
      FMT_I: begin
        pack_ir[11:7]  = in_rd;
        pack_ir[14:12] = in_funct3;
        pack_ir[19:15] = in_rs1;
        pack_ir[31:20] = in_imm[11:0];
        pack_err       = in_imm[31:11] != {21{in_imm[31]}};
      end
      FMT_S: begin
        pack_ir[11:7]  = in_imm[4:0];
        pack_ir[14:12] = in_funct3;
        pack_ir[19:15] = in_rs1;
        pack_ir[24:20] = in_rs2;
        pack_ir[31:25] = in_imm[11:5];
        pack_err       = in_imm[31:11] != {21{in_imm[31]}};
      end
      FMT_B: begin
        pack_ir[7]     = in_imm[11];
        pack_ir[11:8]  = in_imm[4:1];
        pack_ir[14:12] = in_funct3;
        pack_ir[19:15] = in_rs1;
        pack_ir[24:20] = in_rs2;
        pack_ir[30:25] = in_imm[10:5];
        pack_ir[31]    = in_imm[12];
        pack_err       = (in_imm[31:12] != {20{in_imm[31]}}) || in_imm[0];
      end
      FMT_U: begin
        pack_ir[11:7]  = in_rd;
        pack_ir[31:12] = in_imm[31:12];
        pack_err       = |in_imm[11:0];
      end
      FMT_J: begin
        pack_ir[11:7]  = in_rd;
        pack_ir[19:12] = in_imm[19:12];
        pack_ir[20]    = in_imm[11];
        pack_ir[30:21] = in_imm[10:1];
        pack_ir[31]    = in_imm[20];
        pack_err       = (in_imm[31:20] != {12{in_imm[31]}}) || in_imm[0];
      end
      FMT_R: begin
        pack_ir[11:7]  = in_rd;
        pack_ir[14:12] = in_funct3;
        pack_ir[19:15] = in_rs1;
        pack_ir[24:20] = in_rs2;
        pack_ir[31:25] = in_funct7;
      end
      default: pack_err = 1'b1;
    endcase
  end

  // Stage 2 refills whenever it is empty or draining; stage 1 follows it.
  assign s2_load  = !out_valid_q || out_ready;
  assign s2_take  = s2_load && s1_valid_q;
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_ir_d      = s1_ir_q;
    s1_err_d     = s1_err_q;
    out_valid_d  = out_valid_q;
    out_ir_d     = out_ir_q;
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;
    enc_count_d  = enc_count_q;

    if (s2_load) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_ir_d    = pack_ir;
      s1_err_d   = pack_err;
    end

    if (s2_load) out_valid_d = s1_valid_q;
    if (s2_take) begin
      out_ir_d  = s1_ir_q;
      out_err_d = s1_err_q;
    end

    // A new error outranks a clear arriving in the same cycle.
    if (err_clr)             err_sticky_d = 1'b0;
    if (s2_take && s1_err_q) err_sticky_d = 1'b1;

    if (out_valid_q && out_ready) enc_count_d = enc_count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ir_q     <= '0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      enc_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_ir_q     <= out_ir_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      enc_count_q  <= enc_count_d;
    end
  end

  // NOTE: the stage-1 payload is left without reset; it is only consumed
  // when s1_valid_q is set, which the reset does clear.
  always_ff @(posedge clk) begin
    s1_ir_q  <= s1_ir_d;
    s1_err_q <= s1_err_d;
  end

  assign out_valid  = out_valid_q;
  assign out_ir     = out_ir_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
  assign enc_count  = enc_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: accepted jobs are modelled into a queue
// and popped when the output handshakes; scenario tasks add timing checks.
module tb_imm_encoder;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } job_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_fmt = '0;
  logic [6:0]       in_opcode = '0;
  logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]       in_funct3 = '0;
  logic [6:0]       in_funct7 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_ir;
  logic             out_err;
  logic             err_sticky;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] enc_count;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb[$];
  int          exp_count = 0;
  bit          rand_done;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_err(out_err), .err_sticky(err_sticky),
    .err_clr(err_clr), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  function automatic job_t mk(input int fmt, input int opc, input int rd,
                              input int rs1, input int rs2, input int f3,
                              input int f7, input logic [31:0] imm);
    job_t j;
    j.fmt = 3'(fmt); j.opc = 7'(opc); j.rd = 5'(rd); j.rs1 = 5'(rs1);
    j.rs2 = 5'(rs2); j.f3 = 3'(f3); j.f7 = 7'(f7); j.imm = imm;
    return j;
  endfunction

  // Reference encoding built from whole-word concatenations and signed ranges.
  function automatic logic [32:0] model(input job_t j);
    logic [31:0] ir;
    logic        err;
    int signed   v;
    v = $signed(j.imm);
    case (j.fmt)
      3'd0: begin ir = {j.imm[11:0], j.rs1, j.f3, j.rd, j.opc};
                  err = (v < -2048) || (v > 2047); end
      3'd1: begin ir = {j.imm[11:5], j.rs2, j.rs1, j.f3, j.imm[4:0], j.opc};
                  err = (v < -2048) || (v > 2047); end
      3'd2: begin ir = {j.imm[12], j.imm[10:5], j.rs2, j.rs1, j.f3, j.imm[4:1], j.imm[11], j.opc};
                  err = (v < -4096) || (v > 4095) || j.imm[0]; end
      3'd3: begin ir = {j.imm[31:12], j.rd, j.opc}; err = (j.imm[11:0] != 12'd0); end
      3'd4: begin ir = {j.imm[20], j.imm[10:1], j.imm[11], j.imm[19:12], j.rd, j.opc};
                  err = (v < -(1 << 20)) || (v > (1 << 20) - 1) || j.imm[0]; end
      3'd5: begin ir = {j.f7, j.rs2, j.rs1, j.f3, j.rd, j.opc}; err = 1'b0; end
      default: begin ir = {25'd0, j.opc}; err = 1'b1; end
    endcase
    return {err, ir};
  endfunction

  function automatic job_t cur_job();
    return mk(int'(in_fmt), int'(in_opcode), int'(in_rd), int'(in_rs1), int'(in_rs2),
              int'(in_funct3), int'(in_funct7), in_imm);
  endfunction

  // Scoreboard: pop on output handshake, push on input handshake.
  always @(negedge clk) begin
    logic [32:0] exp;
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got ir=%h err=%b, required no output", out_ir, out_err);
        end else begin
          exp = sb.pop_front();
          if ({out_err, out_ir} !== exp) begin
            errors++;
            $display("FAIL sb_out: got ir=%h err=%b, required ir=%h err=%b",
                     out_ir, out_err, exp[31:0], exp[32]);
          end
        end
        exp_count++;
      end
      if (in_valid && in_ready) sb.push_back(model(cur_job()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect1(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input job_t j);
    bit ok = 0;
    in_fmt = j.fmt; in_opcode = j.opc; in_rd = j.rd; in_rs1 = j.rs1;
    in_rs2 = j.rs2; in_funct3 = j.f3; in_funct7 = j.f7; in_imm = j.imm;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Single job into an idle pipe; checks exact two-cycle latency and payload.
  task automatic run_one(input string name, input job_t j, input logic [31:0] ir, input logic err);
    out_ready = 1'b1;
    send(j);
    @(negedge clk);
    expect1({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    expect1({name, "_lat2_valid"}, 32'(out_valid), 32'd1);
    expect1({name, "_ir"}, out_ir, ir);
    expect1({name, "_err"}, 32'(out_err), 32'(err));
  endtask

  task automatic drain();
    bit ok = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d queued jobs, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    expect1("rst_out_valid", 32'(out_valid), 32'd0);
    expect1("rst_out_ir", out_ir, 32'd0);
    expect1("rst_out_err", 32'(out_err), 32'd0);
    expect1("rst_sticky", 32'(err_sticky), 32'd0);
    expect1("rst_count", 32'(enc_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    expect1("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic test_vectors();
    run_one("i_neg1", mk(0, 'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 32'hFFF0_0093, 1'b0);
    tick();
    run_one("b_8", mk(2, 'h63, 0, 0, 0, 0, 0, 32'd8), 32'h0000_0463, 1'b0);
    tick();
    run_one("j_800", mk(4, 'h6F, 1, 0, 0, 0, 0, 32'h800), 32'h0010_00EF, 1'b0);
    tick();
    run_one("u_lui", mk(3, 'h37, 5, 0, 0, 0, 0, 32'h1234_5000), 32'h1234_52B7, 1'b0);
    tick();
    run_one("r_add", mk(5, 'h33, 3, 4, 5, 7, 'h20, 32'hDEAD_BEEF), 32'h4052_71B3, 1'b0);
    expect1("r_no_sticky", 32'(err_sticky), 32'd0);
    tick();
  endtask

  task automatic test_sticky();
    run_one("b_odd", mk(2, 'h63, 0, 0, 0, 0, 0, 32'd3), 32'h0000_0163, 1'b1);
    expect1("b_odd_sticky", 32'(err_sticky), 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    expect1("clr_sticky", 32'(err_sticky), 32'd0);
    tick();
    run_one("i_800", mk(0, 'h13, 0, 0, 0, 0, 0, 32'h800), 32'h8000_0013, 1'b1);
    expect1("i_800_sticky", 32'(err_sticky), 32'd1);
    tick();
    err_clr = 1'b1;
    tick();
    @(negedge clk);
    expect1("clr2_sticky", 32'(err_sticky), 32'd0);
    tick();
    // err_clr still high across the load edge: the set must win.
    run_one("fmt7", mk(7, 'h33, 9, 9, 9, 7, 'h7F, 32'h0), 32'h0000_0033, 1'b1);
    expect1("set_wins_sticky", 32'(err_sticky), 32'd1);
    tick();
    err_clr = 1'b0;
    run_one("fmt6", mk(6, 'h13, 1, 2, 3, 1, 0, 32'd4), 32'h0000_0013, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    int base = exp_count;
    out_ready = 1'b1;
    fork
      begin
        send(mk(0, 'h13, 1, 2, 0, 0, 0, 32'd5));
        send(mk(1, 'h23, 0, 3, 4, 2, 0, 32'hFFFF_FFF8));
        send(mk(3, 'h17, 6, 0, 0, 0, 0, 32'hABCD_E000));
        send(mk(4, 'h6F, 0, 0, 0, 0, 0, 32'hFFFF_F000));
      end
      begin
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          expect1("stall_in_ready", 32'(in_ready), 32'd0);
          expect1("stall_out_valid", 32'(out_valid), 32'd1);
          expect1("stall_ir_hold", out_ir, sb[0][31:0]);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    expect1("b2b_jobs", 32'(exp_count - base), 32'd4);
    expect1("b2b_count", 32'(enc_count), 32'(exp_count % (1 << CNT_W)));
    tick();
  endtask

  task automatic test_random();
    int base = exp_count;
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          job_t j;
          j = mk(int'($urandom_range(0, 7)), int'($urandom), int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom), int'($urandom), $urandom);
          case ($urandom_range(0, 3))
            0: ;
            1: j.imm = 32'($signed(int'($urandom_range(0, 8191)) - 4096));
            2: j.imm = {j.imm[31:20] == 12'd0 ? 12'hFFF : 12'h000, j.imm[19:1], 1'b0};
            default: j.imm[11:0] = 12'd0;
          endcase
          if ($urandom_range(0, 3) == 0) tick();
          send(j);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    expect1("rand_jobs", 32'(exp_count - base), 32'd40);
    expect1("rand_count_wrap", 32'(enc_count), 32'(exp_count % (1 << CNT_W)));
    tick();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(mk(0, 'h13, 0, 0, 0, 0, 0, 32'h1000));
    send(mk(5, 'h33, 1, 1, 1, 0, 0, 32'd0));
    @(negedge clk);
    expect1("pre_rst_valid", 32'(out_valid), 32'd1);
    expect1("pre_rst_sticky", 32'(err_sticky), 32'd1);
    #2 rst = 1'b1;
    #1;
    expect1("mid_rst_valid", 32'(out_valid), 32'd0);
    expect1("mid_rst_count", 32'(enc_count), 32'd0);
    expect1("mid_rst_ir", out_ir, 32'd0);
    expect1("mid_rst_sticky", 32'(err_sticky), 32'd0);
    sb.delete();
    exp_count = 0;
    out_ready = 1'b1;
    tick();
    expect1("rst_hold_count", 32'(enc_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    expect1("post_rst_ready", 32'(in_ready), 32'd1);
    tick();
    run_one("post_rst", mk(0, 'h13, 1, 0, 0, 0, 0, 32'hFFFF_FFFF), 32'hFFF0_0093, 1'b0);
    drain();
    expect1("post_rst_count", 32'(enc_count), 32'd1);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_sticky();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter CNT_W, default 16, width of the emitted-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request carries a valid encode job.
REQ-005 in_ready  output  1  block accepts the job this cycle.
REQ-006 in_fmt  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=R, 6/7 illegal.
REQ-007 in_opcode  input  7  placed in IR[6:0].
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_funct3  input  3;  in_funct7  input  7  function fields.
REQ-010 in_imm  input  32  signed byte-offset or value immediate to pack.
REQ-011 out_valid  output  1;  out_ready  input  1  output handshake.
REQ-012 out_ir  output  32  encoded instruction.
REQ-013 out_err  output  1  immediate out of range or illegal format for this out_ir.
REQ-014 err_sticky  output  1;  err_clr  input  1  sticky error flag and its synchronous clear.
REQ-015 enc_count  output  CNT_W  count of completed output handshakes.

Function
REQ-016 Accept on in_valid && in_ready; emit on out_valid && out_ready.
REQ-017 Two registered stages: S1 packs fields and checks range; S2 holds out_ir/out_err; accept-to-out_valid latency exactly 2 cycles when unstalled.
REQ-018 S2 loads when empty or emptying this cycle; S1 advances under the same condition; in_ready = !S1_valid || S1 advancing (combinational from out_ready, no bubble); throughput 1 job/cycle.
REQ-019 Payload in S1/S2 holds stable while valid and not handshaken; out_ir/out_err change only on S2 load.
REQ-020 Common fields: IR[6:0]=opcode; rd in IR[11:7] for I/U/J/R; funct3 IR[14:12] for I/S/B/R; rs1 IR[19:15] for I/S/B/R; rs2 IR[24:20] for S/B/R.
REQ-021 I: IR[31:20]=imm[11:0].
REQ-022 S: IR[31:25]=imm[11:5], IR[11:7]=imm[4:0].
REQ-023 B: IR[31]=imm[12], IR[30:25]=imm[10:5], IR[11:8]=imm[4:1], IR[7]=imm[11].
REQ-024 U: IR[31:12]=imm[31:12].
REQ-025 J: IR[31]=imm[20], IR[30:21]=imm[10:1], IR[20]=imm[11], IR[19:12]=imm[19:12].
REQ-026 R: IR[31:25]=funct7; in_imm ignored, never an error.
REQ-027 Range errors: I/S when imm[31:11] not all equal; B when imm[31:12] not all equal or imm[0]=1; J when imm[31:20] not all equal or imm[0]=1; U when imm[11:0]!=0.
REQ-028 Errored job still emitted with truncated fields per REQ-021..025 and out_err=1; fmt 6/7 emits out_ir={25'b0,opcode}, out_err=1.
REQ-029 err_sticky sets on the S2-load cycle of an out_err=1 job; err_clr clears it; simultaneous set and clear -> set wins.
REQ-030 enc_count increments by 1 per output handshake, wraps from all-ones to 0.

Reset
REQ-031 rst asserted: S1/S2 valid=0, out_valid=0, out_ir=0, out_err=0, err_sticky=0, enc_count=0, immediately, regardless of clk.
REQ-032 Reset mid-operation discards in-flight jobs; no output handshake on the reset cycle; in_ready=1 first cycle after release.

Verification
REQ-033 I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, out_ready=1 -> out_ir=0xFFF00093, out_err=0, two cycles after accept.
REQ-034 B, opcode 0x63, rs1=rs2=0, funct3=0, imm=8 -> 0x00000463; same with imm=3 -> out_err=1, err_sticky=1.
REQ-035 J, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF; U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-036 I with imm=0x800 -> out_err=1; then err_clr pulse -> err_sticky=0; fmt=7 -> out_err=1.
REQ-037 Back-to-back 4 jobs, out_ready low 3 cycles mid-stream -> in_ready drops after 2 buffered jobs, no loss/duplication, order kept, enc_count=4.
REQ-038 rst asserted with both stages full -> out_valid=0, enc_count=0 at once; next accepted job emerges 2 cycles later.
